// File: rtl/cim_core_pkg.sv
// -----------------------------------------------------------------------------
// cim_core_pkg
// Shared types and default widths for the CIM core memory subsystem.
//   arb_mode_e : arbitration policy selected by csr_arb_mode_i
//   owner_e    : identifies which requester owns a grant / response
// -----------------------------------------------------------------------------
package cim_core_pkg;

   localparam int unsigned MEM_ADDR_WIDTH_DEF = 10;
   localparam int unsigned MEM_DATA_WIDTH_DEF = 64;
   localparam int unsigned MAX_WAIT_DEF       = 15;
   localparam int unsigned WAIT_W_DEF         = 4;

   typedef enum logic [1:0] {
      ARB_RR        = 2'd0,
      ARB_CTRL_ONLY = 2'd1,
      ARB_AXI_ONLY  = 2'd2,
      ARB_CTRL_PRIO = 2'd3
   } arb_mode_e;

   typedef enum logic {
      OWNER_AXI  = 1'b0,
      OWNER_CTRL = 1'b1
   } owner_e;

endpackage

// File: rtl/cim_core_arb_rr2.sv
// -----------------------------------------------------------------------------
// cim_core_arb_rr2
// Two-way combinational grant decision between the AXI path and the CIM
// controller. Purely combinational; state (last owner, wait counter) lives in
// the parent.
//   mode        : arbitration policy
//   lock        : controller requests to keep ownership across a sequence
//   axi_req     : AXI side request
//   ctrl_req    : controller request
//   wait_at_max : AXI side has waited the maximum allowed number of cycles
//   last_owner  : owner of the most recent grant
//   axi_gnt     : grant to AXI side
//   ctrl_gnt    : grant to controller
//   forced      : AXI grant was issued by the starvation override
// -----------------------------------------------------------------------------
module cim_core_arb_rr2
   import cim_core_pkg::*;
(
   input  arb_mode_e mode,
   input  logic      lock,
   input  logic      axi_req,
   input  logic      ctrl_req,
   input  logic      wait_at_max,
   input  owner_e    last_owner,
   output logic      axi_gnt,
   output logic      ctrl_gnt,
   output logic      forced
);

   always_comb begin
      axi_gnt  = 1'b0;
      ctrl_gnt = 1'b0;
      forced   = 1'b0;
      case (mode)
         ARB_CTRL_ONLY: ctrl_gnt = ctrl_req;
         ARB_AXI_ONLY:  axi_gnt  = axi_req;
         default: begin
            // Starvation override beats the controller lock.
            if (wait_at_max && axi_req) begin
               axi_gnt = 1'b1;
               forced  = 1'b1;
            end else if (lock && (last_owner == OWNER_CTRL) && ctrl_req) begin
               ctrl_gnt = 1'b1;
            end else if (axi_req && ctrl_req) begin
               // Conflict: ctrl-priority always favours ctrl; round-robin
               // favours whoever did not win last time.
               if ((mode == ARB_CTRL_PRIO) || (last_owner == OWNER_AXI)) begin
                  ctrl_gnt = 1'b1;
               end else begin
                  axi_gnt = 1'b1;
               end
            end else begin
               axi_gnt  = axi_req;
               ctrl_gnt = ctrl_req;
            end
         end
      endcase
   end

endmodule

// File: rtl/cim_core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cim_core_mem_arbiter
// Dynamic arbiter for the single-port CIM core SRAM, shared by the AXI slave
// path and the CIM controller. Grants are decided combinationally each cycle
// (at most one), the winner's fields are muxed onto the memory port, and the
// 1-cycle-latency read data is routed back to the recorded owner only.
//
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   csr_arb_mode_i             : 0=round-robin 1=ctrl-only 2=axi-only 3=ctrl-prio
//   ctrl_lock_i                : controller holds ownership across a sequence
//   axi_* / ctrl_* (in)        : req, we, addr, be, wdata of each requester
//   axi_gnt_o / ctrl_gnt_o     : request accepted this cycle
//   axi_rvalid_o/ctrl_rvalid_o : response valid, one cycle after grant
//   axi_rdata_o / ctrl_rdata_o : read data to owner, zero otherwise
//   mem_*_o                    : memory request fields (zero when idle)
//   mem_rdata_i                : memory read data, one cycle after request
//   axi_starved_o              : sticky, a forced AXI grant has occurred
//   busy_o                     : a response is outstanding
// -----------------------------------------------------------------------------
module cim_core_mem_arbiter
   import cim_core_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
   parameter int unsigned MEM_DATA_WIDTH = MEM_DATA_WIDTH_DEF,
   parameter int unsigned MAX_WAIT       = MAX_WAIT_DEF,
   parameter int unsigned WAIT_W         = WAIT_W_DEF
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [1:0]                  csr_arb_mode_i,
   input  logic                        ctrl_lock_i,

   input  logic                        axi_req_i,
   input  logic                        axi_we_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   axi_addr_i,
   input  logic [MEM_DATA_WIDTH/8-1:0] axi_be_i,
   input  logic [MEM_DATA_WIDTH-1:0]   axi_wdata_i,
   output logic                        axi_gnt_o,
   output logic                        axi_rvalid_o,
   output logic [MEM_DATA_WIDTH-1:0]   axi_rdata_o,

   input  logic                        ctrl_req_i,
   input  logic                        ctrl_we_i,
   input  logic [MEM_ADDR_WIDTH-1:0]   ctrl_addr_i,
   input  logic [MEM_DATA_WIDTH/8-1:0] ctrl_be_i,
   input  logic [MEM_DATA_WIDTH-1:0]   ctrl_wdata_i,
   output logic                        ctrl_gnt_o,
   output logic                        ctrl_rvalid_o,
   output logic [MEM_DATA_WIDTH-1:0]   ctrl_rdata_o,

   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [MEM_DATA_WIDTH/8-1:0] mem_be_o,
   output logic [MEM_DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata_i,

   output logic                        axi_starved_o,
   output logic                        busy_o
);

   arb_mode_e         mode;
   owner_e            last_owner_q;
   owner_e            rsp_owner_q;
   owner_e            winner;
   logic              rsp_valid_q;
   logic              starved_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic              wait_at_max;
   logic              raw_axi_gnt;
   logic              raw_ctrl_gnt;
   logic              forced;

   assign mode        = arb_mode_e'(csr_arb_mode_i);
   assign wait_at_max = (wait_cnt_q == WAIT_W'(MAX_WAIT));

   cim_core_arb_rr2 u_arb (
      .mode        (mode),
      .lock        (ctrl_lock_i),
      .axi_req     (axi_req_i),
      .ctrl_req    (ctrl_req_i),
      .wait_at_max (wait_at_max),
      .last_owner  (last_owner_q),
      .axi_gnt     (raw_axi_gnt),
      .ctrl_gnt    (raw_ctrl_gnt),
      .forced      (forced)
   );

   // Grants are masked while reset is asserted so the memory sees no request
   // even if requesters keep req high through reset.
   assign axi_gnt_o  = raw_axi_gnt  & rst_ni;
   assign ctrl_gnt_o = raw_ctrl_gnt & rst_ni;
   assign mem_req_o  = axi_gnt_o | ctrl_gnt_o;
   assign winner     = ctrl_gnt_o ? OWNER_CTRL : OWNER_AXI;

   // Memory port mux: winner's fields, all-zero when idle.
   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (axi_gnt_o) begin
         mem_we_o    = axi_we_i;
         mem_addr_o  = axi_addr_i;
         mem_be_o    = axi_be_i;
         mem_wdata_o = axi_wdata_i;
      end else if (ctrl_gnt_o) begin
         mem_we_o    = ctrl_we_i;
         mem_addr_o  = ctrl_addr_i;
         mem_be_o    = ctrl_be_i;
         mem_wdata_o = ctrl_wdata_i;
      end
   end

   // Starvation counter saturates at MAX_WAIT so the override stays armed
   // even after long stretches in a mode that never grants AXI.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q <= '0;
      end else if (!axi_req_i || axi_gnt_o) begin
         wait_cnt_q <= '0;
      end else if (!wait_at_max) begin
         wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starved_q <= 1'b0;
      end else if (forced && axi_gnt_o) begin
         starved_q <= 1'b1;
      end
   end

   // Response stage: remember who owns the access issued this cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q  <= 1'b0;
         rsp_owner_q  <= OWNER_AXI;
         last_owner_q <= OWNER_AXI;
      end else begin
         rsp_valid_q <= mem_req_o;
         if (mem_req_o) begin
            rsp_owner_q  <= winner;
            last_owner_q <= winner;
         end
      end
   end

   assign axi_rvalid_o  = rsp_valid_q && (rsp_owner_q == OWNER_AXI);
   assign ctrl_rvalid_o = rsp_valid_q && (rsp_owner_q == OWNER_CTRL);
   assign axi_rdata_o   = axi_rvalid_o  ? mem_rdata_i : '0;
   assign ctrl_rdata_o  = ctrl_rvalid_o ? mem_rdata_i : '0;
   assign busy_o        = rsp_valid_q;
   assign axi_starved_o = starved_q;

endmodule
